// File: rtl/dcache_sram_wr_ctrl.sv
// Write-port arbiter for the data-cache SRAM: merges line refills (bursts of
// LINE_WORDS beats) and byte-masked CPU stores onto one registered write port.
module dcache_sram_wr_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = 4,
  parameter int LINE_WORDS = 8,
  localparam int OFF_W     = $clog2(LINE_WORDS),
  localparam int IDX_WIDTH = ADDR_WIDTH - OFF_W
) (
  input  logic                  wr_clk,
  input  logic                  tb_wr_rst,
  input  logic                  fill_req_valid,
  output logic                  fill_req_ready,
  input  logic [IDX_WIDTH-1:0]  fill_req_idx,
  input  logic                  fill_dat_valid,
  output logic                  fill_dat_ready,
  input  logic [DATA_WIDTH-1:0] fill_dat,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [BE_WIDTH-1:0]   st_be,
  output logic                  sram_wr_en,
  output logic [ADDR_WIDTH-1:0] sram_wr_addr,
  output logic [DATA_WIDTH-1:0] sram_wr_data,
  output logic [BE_WIDTH-1:0]   sram_wr_byte_en,
  output logic                  fill_done,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;

  state_e                state_q, state_d;
  logic [OFF_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [IDX_WIDTH-1:0]  line_idx_q, line_idx_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [BE_WIDTH-1:0]   wr_be_q, wr_be_d;
  logic                  fill_done_q, fill_done_d;

  logic last_beat;
  assign last_beat = (beat_cnt_q == OFF_W'(LINE_WORDS - 1));

  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fill_req_valid) state_d = FILL;
      FILL:    if (fill_dat_valid && last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A refill request always beats a store presented in the same IDLE cycle.
  always_comb begin
    fill_req_ready = (state_q == IDLE);
    st_ready       = (state_q == IDLE) && !fill_req_valid;
    fill_dat_ready = (state_q == FILL);

    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_be_d     = wr_be_q;
    beat_cnt_d  = beat_cnt_q;
    line_idx_d  = line_idx_q;
    fill_done_d = (state_q == DONE);

    if (fill_req_valid && fill_req_ready) begin
      line_idx_d = fill_req_idx;
      beat_cnt_d = '0;
    end else if (st_valid && st_ready) begin
      wr_en_d   = 1'b1;
      wr_addr_d = st_addr;
      wr_data_d = st_data;
      wr_be_d   = st_be;
    end else if (fill_dat_valid && fill_dat_ready) begin
      wr_en_d    = 1'b1;
      wr_addr_d  = {line_idx_q, beat_cnt_q};
      wr_data_d  = fill_dat;
      wr_be_d    = '1;
      beat_cnt_d = beat_cnt_q + 1'b1;
    end
  end

  // Write port is fully registered; address/data/enables hold between writes.
  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      beat_cnt_q  <= '0;
      line_idx_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_be_q     <= '0;
      fill_done_q <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      line_idx_q  <= line_idx_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_be_q     <= wr_be_d;
      fill_done_q <= fill_done_d;
    end
  end

  assign sram_wr_en      = wr_en_q;
  assign sram_wr_addr    = wr_addr_q;
  assign sram_wr_data    = wr_data_q;
  assign sram_wr_byte_en = wr_be_q;
  assign fill_done       = fill_done_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_dcache_sram_wr_ctrl.sv
// Bench for dcache_sram_wr_ctrl: directed scenarios plus random traffic,
// checked against a transaction-level model and a behavioural SRAM.
module tb_dcache_sram_wr_ctrl;
  localparam int LW = 8;

  logic        wr_clk = 1'b0;
  logic        tb_wr_rst;
  logic        fill_req_valid, fill_req_ready;
  logic [5:0]  fill_req_idx;
  logic        fill_dat_valid, fill_dat_ready;
  logic [31:0] fill_dat;
  logic        st_valid, st_ready;
  logic [8:0]  st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic        sram_wr_en;
  logic [8:0]  sram_wr_addr;
  logic [31:0] sram_wr_data;
  logic [3:0]  sram_wr_byte_en;
  logic        fill_done, busy;

  dcache_sram_wr_ctrl dut (
    .wr_clk(wr_clk), .tb_wr_rst(tb_wr_rst),
    .fill_req_valid(fill_req_valid), .fill_req_ready(fill_req_ready),
    .fill_req_idx(fill_req_idx),
    .fill_dat_valid(fill_dat_valid), .fill_dat_ready(fill_dat_ready),
    .fill_dat(fill_dat),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_be(st_be),
    .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr),
    .sram_wr_data(sram_wr_data), .sram_wr_byte_en(sram_wr_byte_en),
    .fill_done(fill_done), .busy(busy)
  );

  always #5 wr_clk = ~wr_clk;

  int n_assert = 0;
  int n_fail   = 0;
  int n_we     = 0;
  int n_done   = 0;

  // Reference model: where the controller is, and what memory should hold.
  bit          m_fill, m_done;
  logic [5:0]  m_idx;
  int          m_beat;
  logic        acc_st;
  logic [31:0] exp_mem [512];
  logic [31:0] sram    [512];

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  always @(posedge wr_clk)
    if (sram_wr_en === 1'b1)
      sram[sram_wr_addr] <= merge(sram[sram_wr_addr], sram_wr_data, sram_wr_byte_en);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fill = 0; m_done = 0; m_beat = 0;
  endtask

  // One clock: check readies, predict the handshake, check the registered write.
  task automatic cycle();
    bit          idle, was_done, exp_we;
    logic [8:0]  ea;
    logic [31:0] ed;
    logic [3:0]  eb;
    #1;
    idle = !m_fill && !m_done;
    chk("fill_req_ready", 32'(fill_req_ready), 32'(idle));
    chk("st_ready", 32'(st_ready), 32'(idle && !fill_req_valid));
    chk("fill_dat_ready", 32'(fill_dat_ready), 32'(m_fill));
    chk("busy", 32'(busy), 32'(!idle));
    exp_we = 0; was_done = m_done; acc_st = 0;
    ea = '0; ed = '0; eb = '0;
    if (idle && fill_req_valid) begin
      m_fill = 1; m_idx = fill_req_idx; m_beat = 0;
    end else if (idle && st_valid) begin
      exp_we = 1; ea = st_addr; ed = st_data; eb = st_be; acc_st = 1;
    end else if (m_fill && fill_dat_valid) begin
      exp_we = 1; ea = 9'(int'(m_idx) * LW + m_beat); ed = fill_dat; eb = 4'hF;
      m_beat++;
      if (m_beat == LW) begin m_fill = 0; m_done = 1; end
    end else if (m_done) begin
      m_done = 0;
    end
    @(posedge wr_clk); #1;
    chk("wr_en", 32'(sram_wr_en), 32'(exp_we));
    if (exp_we) begin
      chk("wr_addr", 32'(sram_wr_addr), 32'(ea));
      chk("wr_data", sram_wr_data, ed);
      chk("wr_byte_en", 32'(sram_wr_byte_en), 32'(eb));
      exp_mem[ea] = merge(exp_mem[ea], ed, eb);
    end
    chk("fill_done", 32'(fill_done), 32'(was_done));
    if (sram_wr_en === 1'b1) n_we++;
    if (fill_done === 1'b1) n_done++;
  endtask

  task automatic mem_check(input string tag);
    for (int i = 0; i < 512; i++) chk(tag, sram[i], exp_mem[i]);
  endtask

  task automatic idle_inputs();
    fill_req_valid = 0; fill_dat_valid = 0; st_valid = 0;
  endtask

  task automatic refill(input logic [5:0] idx, input bit gaps);
    int k;
    fill_req_valid = 1; fill_req_idx = idx;
    cycle();
    fill_req_valid = 0;
    k = 0;
    for (int c = 0; c < 40 && k < LW; c++) begin
      fill_dat_valid = !(gaps && c[0]);
      fill_dat = 32'hA0 + 32'(k);
      cycle();
      if (fill_dat_valid) k++;
    end
    fill_dat_valid = 0;
    chk("refill_beats_sent", 32'(k), 32'(LW));
    cycle();
    cycle();
  endtask

  initial begin
    tb_wr_rst = 1;
    idle_inputs();
    fill_req_idx = '0; fill_dat = '0; st_addr = '0; st_data = '0; st_be = '0;
    model_reset();
    #12;
    chk("rst_wr_en", 32'(sram_wr_en), 0);
    chk("rst_wr_addr", 32'(sram_wr_addr), 0);
    chk("rst_wr_data", sram_wr_data, 0);
    chk("rst_wr_be", 32'(sram_wr_byte_en), 0);
    chk("rst_fill_done", 32'(fill_done), 0);
    @(posedge wr_clk); #1;
    tb_wr_rst = 0;

    // Idle after reset
    for (int i = 0; i < 10; i++) cycle();

    // Back-to-back stores: full-word pass, then random byte masks
    st_valid = 1;
    for (int i = 0; i < 512; i++) begin
      st_addr = 9'(i); st_data = $urandom; st_be = 4'hF;
      cycle();
    end
    st_addr = 9'h1F3; st_data = 32'hDEADBEEF; st_be = 4'b0101;
    cycle();
    for (int i = 0; i < 512; i++) begin
      st_addr = 9'(i); st_data = $urandom; st_be = 4'($urandom_range(0, 15));
      cycle();
    end
    st_valid = 0;
    cycle();
    mem_check("mem_after_stores");

    // Refill without and with gaps
    n_we = 0; n_done = 0;
    refill(6'h05, 0);
    chk("refill_writes", 32'(n_we), 8);
    chk("refill_done_cnt", 32'(n_done), 1);
    for (int i = 0; i < 8; i++) chk("refill_word", sram[8'h28 + i], 32'hA0 + 32'(i));
    n_we = 0; n_done = 0;
    refill(6'h05, 1);
    chk("gap_refill_writes", 32'(n_we), 8);
    chk("gap_refill_done_cnt", 32'(n_done), 1);

    // Tie in IDLE: refill wins, store waits and keeps its payload
    fill_req_valid = 1; fill_req_idx = 6'h0A;
    st_valid = 1; st_addr = 9'h1C4; st_data = 32'h12345678; st_be = 4'hF;
    cycle();
    fill_req_valid = 0;
    fill_dat_valid = 1;
    for (int c = 0; c < 30 && !acc_st; c++) begin
      fill_dat = $urandom;
      cycle();
    end
    chk("tie_store_accepted", 32'(acc_st), 1);
    st_valid = 0; fill_dat_valid = 0;
    cycle();
    chk("tie_store_word", sram[9'h1C4], 32'h12345678);

    // Reset in the middle of a refill, after the third word is in SRAM
    fill_req_valid = 1; fill_req_idx = 6'h1A;
    cycle();
    fill_req_valid = 0;
    fill_dat_valid = 1;
    for (int k = 0; k < 3; k++) begin fill_dat = 32'hC0DE0000 + 32'(k); cycle(); end
    fill_dat_valid = 0;
    cycle();
    tb_wr_rst = 1;
    #1;
    chk("arst_wr_en", 32'(sram_wr_en), 0);
    chk("arst_wr_addr", 32'(sram_wr_addr), 0);
    chk("arst_wr_data", sram_wr_data, 0);
    chk("arst_wr_be", 32'(sram_wr_byte_en), 0);
    chk("arst_fill_req_ready", 32'(fill_req_ready), 1);
    chk("arst_fill_dat_ready", 32'(fill_dat_ready), 0);
    chk("arst_busy", 32'(busy), 0);
    model_reset();
    @(posedge wr_clk); #1;
    tb_wr_rst = 0;
    mem_check("mem_after_abort");
    st_valid = 1; st_addr = 9'h0D5; st_data = 32'hFEEDF00D; st_be = 4'b1001;
    cycle();
    st_valid = 0;
    cycle();
    chk("post_rst_store", sram[9'h0D5], exp_mem[9'h0D5]);

    // Random mixed traffic
    for (int i = 0; i < 2000; i++) begin
      fill_req_valid = ($urandom_range(0, 15) == 0);
      fill_req_idx   = 6'($urandom);
      fill_dat_valid = ($urandom_range(0, 3) != 0);
      fill_dat       = $urandom;
      st_valid       = 1'($urandom_range(0, 1));
      st_addr        = 9'($urandom);
      st_data        = $urandom;
      st_be          = 4'($urandom);
      cycle();
    end
    idle_inputs();
    for (int i = 0; i < 12; i++) cycle();
    mem_check("mem_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
